// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and AXI constants for the DMA engines
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rdma_state_t;

    localparam int          BEAT_BYTES     = 16;
    localparam int          PAGE_BYTES     = 4096;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - burst length limited by remaining beats, max burst and 4 KB page
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [27:0] remaining,
    input  logic [11:0] page_off,
    output logic [8:0]  len
);

    localparam logic [8:0] MAX_LEN   = 9'(MAX_BURST_LEN);
    localparam logic [8:0] PAGE_BEATS = 9'(PAGE_BYTES / BEAT_BYTES);

    logic [8:0] to_page;
    logic [8:0] cap;

    // Smallest of the three limits; to_page is 1..256 because page_off is beat aligned
    always_comb begin
        to_page = PAGE_BEATS - {1'b0, page_off[11:4]};
        cap     = (MAX_LEN < to_page) ? MAX_LEN : to_page;
        len     = (remaining < 28'(cap)) ? remaining[8:0] : cap;
    end

endmodule

// File: rtl/dma_rdma_engine.sv
// rtl/dma_rdma_engine.sv - read DMA: AXI4 INCR read bursts forwarded as an AXI4-Stream
module dma_rdma_engine
    import dma_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int MAX_BURST_LEN      = 16,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ap_start,
    input  logic [31:0]                   rdma_mem_ptr,
    input  logic [31:0]                   rdma_transfer_byte,
    output logic                          done,
    output logic                          idle,
    output logic                          error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    localparam int         AW      = C_M_AXI_ADDR_WIDTH;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    rdma_state_t   state_q;
    rdma_state_t   state_d;
    logic [AW-1:0] addr_q;
    logic [27:0]   ar_beats_q;
    logic [27:0]   r_beats_q;
    logic [3:0]    outstanding_q;
    logic          error_q;
    logic          arvalid_q;
    logic [AW-1:0] araddr_q;
    logic [7:0]    arlen_q;

    logic [27:0]   start_beats;
    logic [AW-1:0] start_addr;
    logic [27:0]   calc_remaining;
    logic [11:0]   calc_off;
    logic [8:0]    burst_len;
    logic [8:0]    issued_beats;
    logic          in_idle;
    logic          in_run;
    logic          start_ok;
    logic          issue;
    logic          ar_hs;
    logic          r_hs;
    logic          unused_low_bits;

    assign unused_low_bits = ^{rdma_mem_ptr[3:0], rdma_transfer_byte[3:0]};

    assign in_idle     = (state_q == ST_IDLE);
    assign in_run      = (state_q == ST_RUN);
    assign start_beats = rdma_transfer_byte[31:4];
    assign start_addr  = AW'({rdma_mem_ptr[31:4], 4'h0});
    assign start_ok    = in_idle && ap_start;

    // In IDLE the first burst is sized from the inputs so ARVALID can rise right after start
    assign calc_remaining = in_idle ? start_beats : ar_beats_q;
    assign calc_off       = in_idle ? start_addr[11:0] : addr_q[11:0];

    dma_burst_calc #(
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .remaining (calc_remaining),
        .page_off  (calc_off),
        .len       (burst_len)
    );

    assign issue        = in_run && !arvalid_q && (ar_beats_q != 28'd0) && (outstanding_q < MAX_OUT);
    assign ar_hs        = arvalid_q && ARREADY;
    assign issued_beats = {1'b0, arlen_q} + 9'd1;

    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARVALID = arvalid_q;
    assign ARSIZE  = AXI_SIZE_16B;
    assign ARBURST = AXI_BURST_INCR;

    assign RREADY        = in_run && m_axis_tready;
    assign m_axis_tvalid = in_run && RVALID;
    assign m_axis_tdata  = RDATA;
    assign m_axis_tlast  = (r_beats_q == 28'd1);
    assign r_hs          = RVALID && RREADY;
    assign error         = error_q;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_d = state_q;
        idle    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (ap_start) begin
                    state_d = (start_beats != 28'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (r_hs && (r_beats_q == 28'd1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address/beat bookkeeping, AR channel registers and sticky error
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q        <= '0;
            ar_beats_q    <= '0;
            r_beats_q     <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
        end else if (start_ok) begin
            addr_q        <= start_addr;
            ar_beats_q    <= start_beats;
            r_beats_q     <= start_beats;
            outstanding_q <= '0;
            error_q       <= 1'b0;
            if (start_beats != 28'd0) begin
                arvalid_q <= 1'b1;
                araddr_q  <= start_addr;
                arlen_q   <= 8'(burst_len - 9'd1);
            end
        end else if (in_run) begin
            if (issue) begin
                arvalid_q <= 1'b1;
                araddr_q  <= addr_q;
                arlen_q   <= 8'(burst_len - 9'd1);
            end
            if (ar_hs) begin
                arvalid_q  <= 1'b0;
                addr_q     <= addr_q + AW'({issued_beats, 4'h0});
                ar_beats_q <= ar_beats_q - 28'(issued_beats);
            end
            if (r_hs) begin
                r_beats_q <= r_beats_q - 28'd1;
                if (RRESP != AXI_RESP_OKAY) begin
                    error_q <= 1'b1;
                end
            end
            case ({ar_hs, r_hs && RLAST})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rdma_engine.sv
// tb/tb_dma_rdma_engine.sv - self-checking bench for dma_rdma_engine
module tb_dma_rdma_engine;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         ap_start = 1'b0;
    logic [31:0]  rdma_mem_ptr = '0;
    logic [31:0]  rdma_transfer_byte = '0;
    logic         done;
    logic         idle;
    logic         error;
    logic [31:0]  ARADDR;
    logic [7:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY = 1'b0;
    logic [127:0] RDATA = '0;
    logic [1:0]   RRESP = '0;
    logic         RLAST = 1'b0;
    logic         RVALID = 1'b0;
    logic         RREADY;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;

    dma_rdma_engine dut (
        .ACLK               (ACLK),
        .ARESETN            (ARESETN),
        .ap_start           (ap_start),
        .rdma_mem_ptr       (rdma_mem_ptr),
        .rdma_transfer_byte (rdma_transfer_byte),
        .done               (done),
        .idle               (idle),
        .error              (error),
        .ARADDR             (ARADDR),
        .ARLEN              (ARLEN),
        .ARSIZE             (ARSIZE),
        .ARBURST            (ARBURST),
        .ARVALID            (ARVALID),
        .ARREADY            (ARREADY),
        .RDATA              (RDATA),
        .RRESP              (RRESP),
        .RLAST              (RLAST),
        .RVALID             (RVALID),
        .RREADY             (RREADY),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // Reference model: burst list and beat stream derived from the transfer rules
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t          exp_ar[$];
    logic [127:0] exp_data[$];
    logic         exp_last[$];
    int           exp_beats = 0;
    bit           exp_err = 0;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
    endfunction

    task automatic build_model(input logic [31:0] ptr, input logic [31:0] bytes);
        longint a;
        longint rem;
        longint l;
        longint pg;
        a   = longint'(ptr & ~32'hF);
        rem = longint'(bytes >> 4);
        exp_ar.delete();
        exp_data.delete();
        exp_last.delete();
        for (longint i = 0; i < rem; i++) begin
            exp_data.push_back(mem_word(32'(a + 16 * i)));
            exp_last.push_back(i == rem - 1);
        end
        while (rem > 0) begin
            pg = (4096 - (a % 4096)) / 16;
            l  = rem;
            if (l > 16) l = 16;
            if (l > pg) l = pg;
            exp_ar.push_back({32'(a), 8'(l - 1)});
            a   = a + 16 * l;
            rem = rem - l;
        end
    endtask

    // Memory slave state
    logic [31:0] slv_addr[$];
    logic        slv_last[$];
    int          ar_stall = 0;
    bit          tready_toggle = 0;
    int          err_beat = -1;
    int          slv_beat = 0;
    bit          ar_fire_s = 0;
    bit          r_fire_s = 0;
    logic [31:0] ar_addr_s = '0;
    logic [7:0]  ar_len_s = '0;

    // Memory slave: applies handshakes sampled at the previous negedge, then drives R/AR ready
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (ar_fire_s) begin
                for (int k = 0; k <= int'(ar_len_s); k++) begin
                    slv_addr.push_back(ar_addr_s + 32'(16 * k));
                    slv_last.push_back(k == int'(ar_len_s));
                end
            end
            if (r_fire_s && slv_addr.size() > 0) begin
                void'(slv_addr.pop_front());
                void'(slv_last.pop_front());
                slv_beat++;
            end
            ar_fire_s = 0;
            r_fire_s  = 0;
            ARREADY = (ar_stall == 0);
            if (ar_stall > 0) ar_stall--;
            if (tready_toggle) m_axis_tready = ~m_axis_tready;
            if (slv_addr.size() > 0) begin
                RVALID = 1'b1;
                RDATA  = mem_word(slv_addr[0]);
                RLAST  = slv_last[0];
                RRESP  = (slv_beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                RVALID = 1'b0;
                RDATA  = '0;
                RLAST  = 1'b0;
                RRESP  = 2'b00;
            end
        end
    end

    // Compare process state
    int          cyc = 0;
    int          start_cyc = -10;
    int          done_cyc = -10;
    int          last_cyc = -10;
    int          ar_cnt = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          outst = 0;
    bit          in_run = 0;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    // Compare process: checks every cycle's outputs against the model, sampled at negedge
    initial begin
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESETN) begin
                prev_pend = 0;
            end else begin
                if (prev_pend) begin
                    check("ar_hold_valid", ARVALID, 1);
                    check("ar_hold_addr", ARADDR, prev_addr);
                    check("ar_hold_len", ARLEN, prev_len);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    in_run   = 0;
                    check("done_timing", cyc, (exp_beats > 0) ? last_cyc + 1 : start_cyc + 1);
                    check("error_at_done", error, exp_err);
                end
                if (cyc == done_cyc + 1) check("idle_after_done", idle, 1);
                if (cyc == start_cyc + 1) begin
                    check("idle_after_start", idle, 0);
                    check("error_cleared", error, 0);
                    if (exp_beats > 0) begin
                        check("arvalid_after_start", ARVALID, 1);
                        in_run = 1;
                    end else begin
                        check("done_zero_byte", done, 1);
                    end
                end
                if (in_run) begin
                    check("rready_follows_tready", RREADY, m_axis_tready);
                    check("tvalid_follows_rvalid", m_axis_tvalid, RVALID);
                end
                if (ARVALID && ARREADY) begin
                    ar_fire_s = 1;
                    ar_addr_s = ARADDR;
                    ar_len_s  = ARLEN;
                    ar_cnt++;
                    outst++;
                    if (exp_ar.size() == 0) begin
                        fail_now("ar_unexpected");
                    end else begin
                        ar_t e;
                        e = exp_ar.pop_front();
                        check("araddr", ARADDR, e.addr);
                        check("arlen", ARLEN, e.len);
                        check("arsize_arburst", {ARSIZE, ARBURST}, {3'b100, 2'b01});
                    end
                end
                if (RVALID && RREADY) begin
                    r_fire_s = 1;
                    if (RLAST) outst--;
                end
                if (ARVALID && ARREADY) check("outstanding_limit", outst <= 4, 1);
                if (m_axis_tvalid && m_axis_tready) begin
                    beat_cnt++;
                    if (exp_data.size() == 0) begin
                        fail_now("beat_unexpected");
                    end else begin
                        logic [127:0] d;
                        logic         l;
                        d = exp_data.pop_front();
                        l = exp_last.pop_front();
                        check("tdata", m_axis_tdata, d);
                        check("tlast", m_axis_tlast, l);
                        if (l) last_cyc = cyc;
                    end
                end
                prev_pend = ARVALID && !ARREADY;
                prev_addr = ARADDR;
                prev_len  = ARLEN;
                if (ap_start && idle) start_cyc = cyc;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] ptr, input logic [31:0] bytes,
                              input int stall, input bit toggle, input int errb);
        build_model(ptr, bytes);
        exp_beats     = int'(bytes >> 4);
        exp_err       = (errb >= 0) && (errb < exp_beats);
        err_beat      = errb;
        slv_beat      = 0;
        ar_cnt        = 0;
        beat_cnt      = 0;
        done_cnt      = 0;
        outst         = 0;
        ar_stall      = stall;
        tready_toggle = toggle;
        if (!toggle) m_axis_tready = 1'b1;
        @(posedge ACLK);
        #1;
        ap_start           = 1'b1;
        rdma_mem_ptr       = ptr;
        rdma_transfer_byte = bytes;
        @(posedge ACLK);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic run(input logic [31:0] ptr, input logic [31:0] bytes,
                       input int stall, input bit toggle, input int errb);
        int n_ar;
        start_xfer(ptr, bytes, stall, toggle, errb);
        n_ar = exp_ar.size() + ar_cnt;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge ACLK);
        check("done_seen", done_cnt > 0, 1);
        repeat (3) @(posedge ACLK);
        #1;
        check("done_once", done_cnt, 1);
        check("ar_count", ar_cnt, n_ar);
        check("beat_count", beat_cnt, exp_beats);
        tready_toggle = 0;
        m_axis_tready = 1'b1;
    endtask

    initial begin
        m_axis_tready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_idle", idle, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_arlen", ARLEN, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_rready", RREADY, 0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        build_model(32'h1000, 32'h400);
        check("model_t1_ars", exp_ar.size(), 4);
        check("model_t1_ar0", exp_ar[0], {32'h1000, 8'd15});
        check("model_t1_ar3", exp_ar[3], {32'h1300, 8'd15});
        check("model_t1_beats", exp_data.size(), 64);
        run(32'h1000, 32'h400, 0, 0, -1);
        check("t1_ar_count", ar_cnt, 4);
        check("t1_beat_count", beat_cnt, 64);

        build_model(32'h0FC0, 32'h80);
        check("model_t2_ar0", exp_ar[0], {32'h0FC0, 8'd3});
        check("model_t2_ar1", exp_ar[1], {32'h1000, 8'd3});
        run(32'h0FC0, 32'h80, 0, 0, -1);
        check("t2_ar_count", ar_cnt, 2);

        run(32'h3000, 32'h0, 0, 0, -1);
        check("t3_no_ar", ar_cnt, 0);

        run(32'h4007, 32'h100F, 10, 1, -1);
        check("t4_beat_count", beat_cnt, 256);

        run(32'h5000, 32'h100, 0, 0, 4);
        run(32'h5100, 32'h40, 0, 0, -1);

        build_model(32'hFFFF_FFE0, 32'h40);
        check("model_wrap_ar0", exp_ar[0], {32'hFFFF_FFE0, 8'd1});
        check("model_wrap_ar1", exp_ar[1], {32'h0000_0000, 8'd1});
        run(32'hFFFF_FFE0, 32'h40, 0, 0, -1);

        start_xfer(32'h1000, 32'h400, 0, 0, 2);
        repeat (20) @(posedge ACLK);
        #1;
        check("error_before_reset", error, 1);
        ARESETN = 1'b0;
        #2;
        check("mid_rst_arvalid", ARVALID, 0);
        check("mid_rst_araddr", ARADDR, 0);
        check("mid_rst_arlen", ARLEN, 0);
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_rready", RREADY, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        slv_addr.delete();
        slv_last.delete();
        ar_fire_s = 0;
        r_fire_s  = 0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        in_run    = 0;
        start_cyc = -10;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        run(32'h2000, 32'h200, 0, 0, -1);
        check("t6_ar_count", ar_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_rdma_engine.md
# dma_rdma_engine

Read-DMA engine, directly downstream of the DMA AXI4-Lite control slave. It consumes that slave's `ap_start`, `rdma_mem_ptr` and `rdma_transfer_byte` outputs. For each start it issues AXI4 INCR read bursts to memory and forwards the returned beats as an AXI4-Stream to the FFT datapath. It reports `done`, `idle` and a sticky `error` back toward the control slave's `ap_done`/`ap_idle` logic.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, byte address width.
- `C_M_AXI_DATA_WIDTH`, 128, beat width; `BEAT_BYTES` = 16.
- `MAX_BURST_LEN`, 16, beats per burst (1..256).
- `MAX_OUTSTANDING`, 4, bursts in flight (1..15).

Ports:
- `ACLK` in 1: sole clock.
- `ARESETN` in 1: reset, asynchronous assert, active-low.
- `ap_start` in 1: start request, sampled only in IDLE.
- `rdma_mem_ptr` in 32: start byte address; 16-byte aligned, low 4 bits forced to 0.
- `rdma_transfer_byte` in 32: byte count; low 4 bits ignored (beats = value>>4).
- `done` out 1: one-cycle pulse at completion.
- `idle` out 1: high in IDLE.
- `error` out 1: sticky, set on any RRESP≠OKAY, cleared at next accepted start.
- AR channel: `ARADDR` out ADDR_WIDTH, `ARLEN` out 8, `ARSIZE` out 3 (const 3'b100), `ARBURST` out 2 (const 2'b01), `ARVALID` out 1, `ARREADY` in 1.
- R channel: `RDATA` in DATA_WIDTH, `RRESP` in 2, `RLAST` in 1, `RVALID` in 1, `RREADY` out 1.
- Stream out: `m_axis_tdata` out DATA_WIDTH, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `ap_start`=1 latches the address, latches `ar_beats` = `r_beats` = `rdma_transfer_byte`>>4, and clears `error`.
  - Goes to RUN if beats>0, else DONE.
- RUN, AR side:
  - A burst is issued when `ar_beats`>0, outstanding<MAX_OUTSTANDING and no AR is pending.
  - `len` = min(`ar_beats`, MAX_BURST_LEN, (4096−addr[11:0])/16), so a burst never crosses a 4 KB boundary.
  - Drives `ARLEN`=len−1.
  - On AR handshake: addr += len·16, `ar_beats` −= len, outstanding += 1.
- RUN, R side:
  - `RREADY`=`m_axis_tready`; `m_axis_tvalid`=`RVALID` (RUN only); `m_axis_tdata`=`RDATA`.
  - `m_axis_tlast`=(`r_beats`==1).
  - Each R handshake: `r_beats` −= 1; RRESP≠0 sets `error`; beat still forwarded.
  - R handshake with `RLAST` decrements outstanding.
  - AR handshake and RLAST handshake in the same cycle leave outstanding unchanged.
- RUN→DONE when the R handshake takes `r_beats` 1→0.
- DONE: `done`=1 for one cycle, then IDLE.
- `ap_start` outside IDLE is ignored; parameters are not re-sampled.
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap, no flag).
- Counters: `ar_beats`/`r_beats` 28 bits, outstanding 4 bits.

## Timing
- Reset values:
  - State IDLE; `idle`=1; `done`=0; `error`=0; `ARVALID`=0; `ARADDR`=0; `ARLEN`=0.
  - `m_axis_tvalid`=0 and `RREADY`=0 outside RUN.
  - Internal counters 0.
- Start sampled at edge N → `ARVALID` high from cycle N+1; `idle` low from N+1.
- `ARVALID`/`ARADDR`/`ARLEN` are registered and held stable until `ARREADY`.
- R→stream path is combinational, zero latency, no buffering; backpressure passes straight to `RREADY`.
- Last beat handshake at edge M → `done` high cycle M+1, `idle` high M+2, new start accepted at M+2 edge.
- Zero-byte start at edge N → `done` at N+1, no AR issued.
- `ARESETN` low mid-transfer: all state cleared immediately. In-flight AXI transactions are abandoned; the system resets the interconnect together with this block.

## Structure
- Package `dma_pkg`: state enum, `BEAT_BYTES`, `AXI_BURST_INCR`, `AXI_SIZE_16B`, `AXI_RESP_OKAY`, 4 KB page constant.
- Sub-module `dma_burst_calc`: combinational min(remaining, MAX_BURST_LEN, beats-to-4KB). Shared later with the write-DMA engine.

## Test plan
- ptr=0x1000, bytes=0x400 (64 beats), memory ready, tready=1 → 4 ARs (ARLEN=15, addr 0x1000/0x1100/0x1200/0x1300); 64 stream beats; tlast on beat 64; `done` pulse once.
- ptr=0x0FC0, bytes=0x80 → first AR ARLEN=3 @0x0FC0, second ARLEN=3 @0x1000 (4 KB split).
- bytes=0 → `done` exactly one cycle after start, `ARVALID` never asserted.
- ARREADY held low 10 cycles, then tready toggled 1/0 on 256 beats → ARADDR/ARLEN stable while stalled; no beat lost or duplicated; outstanding never exceeds 4.
- Beat 5 returns RRESP=2'b10 → `error`=1 through `done`; all beats forwarded; next start clears `error`.
- `ARESETN` pulsed low mid-burst → outputs at reset values same cycle; subsequent start at ptr=0x2000 completes normally.
